// File: rtl/sa_os_tile.sv
// Output-stationary systolic matrix-multiply tile: C = A x B with run-time K.
// A columns and B rows stream in through skew chains. Each PE keeps its own
// accumulator. After a zero-injecting flush, C is drained one row per handshake.
module sa_os_tile #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int WIDTH = 8,
  parameter int ACC_W = 24,
  parameter int KW    = 8,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic                    signed_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*WIDTH-1:0]   a_data,
  input  logic [COLS*WIDTH-1:0]   b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic [RW-1:0]           out_row,
  output logic                    out_last,
  output logic                    busy
);

  localparam int FL_N = ROWS + COLS - 2;
  localparam int FCW  = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [KW-1:0]      k_len_r, k_cnt_r;
  logic               signed_r;
  logic [FCW-1:0]     fl_cnt_r;
  logic               in_ready_r, out_valid_r, out_last_r, busy_r;
  logic [RW-1:0]      out_row_r, row_nx_s;
  logic [COLS*ACC_W-1:0] out_data_r, row_data_s;

  logic clr_s, beat_s, last_beat_s, adv_s, drain_hs_s, last_row_s;

  logic [WIDTH-1:0] a_src_s  [ROWS];
  logic [WIDTH-1:0] a_left_s [ROWS];
  logic [WIDTH-1:0] b_src_s  [COLS];
  logic [WIDTH-1:0] b_top_s  [COLS];
  logic [WIDTH-1:0] a_h_s    [ROWS][COLS];
  logic [WIDTH-1:0] b_v_s    [ROWS][COLS];
  logic [ACC_W-1:0] acc_nx_s [ROWS][COLS];

  // Full-width product, sign- or zero-extended to the accumulator width.
  function automatic logic [ACC_W-1:0] mac_prod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             sgn);
    logic [2*WIDTH-1:0] ae, be, p;
    logic [ACC_W-1:0]   r;
    ae = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    be = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    p  = ae * be;
    r  = {ACC_W{sgn & p[2*WIDTH-1]}};
    r[2*WIDTH-1:0] = p;
    return r;
  endfunction

  assign clr_s       = (state_r == ST_IDLE) && start && (k_len != {KW{1'b0}});
  assign beat_s      = (state_r == ST_LOAD) && in_ready_r && in_valid;
  assign last_beat_s = (k_cnt_r == (k_len_r - KW'(1)));
  // The array only moves on accepted beats or flush cycles, so input gaps freeze it.
  assign adv_s       = beat_s || (state_r == ST_FLUSH);
  assign drain_hs_s  = (state_r == ST_DRAIN) && out_valid_r && out_ready;
  assign last_row_s  = (out_row_r == RW'(ROWS - 1));

  // A-side skew: row r is delayed r advances; zeros are injected outside LOAD.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    assign a_src_s[r] = (state_r == ST_LOAD) ? a_data[r*WIDTH +: WIDTH] : {WIDTH{1'b0}};
    if (r == 0) begin : g_direct
      assign a_left_s[r] = a_src_s[r];
    end else begin : g_chain
      logic [WIDTH-1:0] sk_r [r];
      // Shift the row's delay chain one stage per advance.
      always_ff @(posedge CLK) begin
        if (RST || clr_s) begin
          for (int d = 0; d < r; d++) sk_r[d] <= {WIDTH{1'b0}};
        end else if (adv_s) begin
          sk_r[0] <= a_src_s[r];
          for (int d = 1; d < r; d++) sk_r[d] <= sk_r[d-1];
        end
      end
      assign a_left_s[r] = sk_r[r-1];
    end
  end

  // B-side skew: column c is delayed c advances.
  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    assign b_src_s[c] = (state_r == ST_LOAD) ? b_data[c*WIDTH +: WIDTH] : {WIDTH{1'b0}};
    if (c == 0) begin : g_direct
      assign b_top_s[c] = b_src_s[c];
    end else begin : g_chain
      logic [WIDTH-1:0] sk_r [c];
      // Shift the column's delay chain one stage per advance.
      always_ff @(posedge CLK) begin
        if (RST || clr_s) begin
          for (int d = 0; d < c; d++) sk_r[d] <= {WIDTH{1'b0}};
        end else if (adv_s) begin
          sk_r[0] <= b_src_s[c];
          for (int d = 1; d < c; d++) sk_r[d] <= sk_r[d-1];
        end
      end
      assign b_top_s[c] = sk_r[c-1];
    end
  end

  // PE grid: A moves right, B moves down, and C stays in place.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic [WIDTH-1:0] a_in_s, b_in_s, a_r, b_r;
      logic [ACC_W-1:0] acc_r;
      if (c == 0) begin : g_al
        assign a_in_s = a_left_s[r];
      end else begin : g_ap
        assign a_in_s = a_h_s[r][c-1];
      end
      if (r == 0) begin : g_bt
        assign b_in_s = b_top_s[c];
      end else begin : g_bp
        assign b_in_s = b_v_s[r-1][c];
      end
      assign acc_nx_s[r][c] = adv_s ? (acc_r + mac_prod(a_in_s, b_in_s, signed_r)) : acc_r;
      // Pass operands on and accumulate on every advance.
      always_ff @(posedge CLK) begin
        if (RST || clr_s) begin
          a_r   <= {WIDTH{1'b0}};
          b_r   <= {WIDTH{1'b0}};
          acc_r <= {ACC_W{1'b0}};
        end else if (adv_s) begin
          a_r   <= a_in_s;
          b_r   <= b_in_s;
          acc_r <= acc_nx_s[r][c];
        end
      end
      assign a_h_s[r][c] = a_r;
      assign b_v_s[r][c] = b_r;
    end
  end

  // Next-state and next drain-row selection.
  always_comb begin
    state_nx_s = state_r;
    row_nx_s   = out_row_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_s) state_nx_s = ST_LOAD;
        else       state_nx_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (beat_s && last_beat_s) begin
          row_nx_s = {RW{1'b0}};
          if (FL_N > 0) state_nx_s = ST_FLUSH;
          else          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        if (fl_cnt_r == FCW'(FL_N - 1)) begin
          state_nx_s = ST_DRAIN;
          row_nx_s   = {RW{1'b0}};
        end else begin
          state_nx_s = ST_FLUSH;
        end
      end
      ST_DRAIN: begin
        if (drain_hs_s) begin
          if (last_row_s) begin
            state_nx_s = ST_IDLE;
            row_nx_s   = {RW{1'b0}};
          end else begin
            state_nx_s = ST_DRAIN;
            row_nx_s   = out_row_r + RW'(1);
          end
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        row_nx_s   = {RW{1'b0}};
      end
    endcase
  end

  // Gather the row about to be presented, using post-edge accumulator values.
  always_comb begin
    row_data_s = {(COLS*ACC_W){1'b0}};
    for (int c = 0; c < COLS; c++) row_data_s[c*ACC_W +: ACC_W] = acc_nx_s[row_nx_s][c];
  end

  // State register, job latches, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      k_len_r     <= {KW{1'b0}};
      signed_r    <= 1'b0;
      k_cnt_r     <= {KW{1'b0}};
      fl_cnt_r    <= {FCW{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_row_r   <= {RW{1'b0}};
      out_data_r  <= {(COLS*ACC_W){1'b0}};
    end else begin
      state_r <= state_nx_s;
      if (clr_s) begin
        k_len_r  <= k_len;
        signed_r <= signed_mode;
        k_cnt_r  <= {KW{1'b0}};
      end else if (beat_s) begin
        k_cnt_r  <= k_cnt_r + KW'(1);
      end
      fl_cnt_r    <= (state_r == ST_FLUSH) ? (fl_cnt_r + FCW'(1)) : {FCW{1'b0}};
      in_ready_r  <= (state_nx_s == ST_LOAD);
      busy_r      <= (state_nx_s != ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DRAIN);
      out_last_r  <= (state_nx_s == ST_DRAIN) && (row_nx_s == RW'(ROWS - 1));
      out_row_r   <= row_nx_s;
      if (state_nx_s == ST_DRAIN) out_data_r <= row_data_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign out_row   = out_row_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_sa_os_tile.sv
// Self-checking bench for sa_os_tile. It compares a 24-bit and a 16-bit
// accumulator instance, both fed the same stimulus, against a plain matmul model.
module tb_sa_os_tile;
  localparam int R = 4, C = 4, W = 8, KM = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST, start, signed_mode, in_valid, out_ready;
  logic [7:0] k_len;
  logic [R*W-1:0] a_data;
  logic [C*W-1:0] b_data;
  logic in_ready, out_valid, out_last, busy;
  logic [C*24-1:0] out_data;
  logic [1:0] out_row;
  logic in_ready16, out_valid16, out_last16, busy16;
  logic [C*16-1:0] out_data16;
  logic [1:0] out_row16;

  int tests = 0, fails = 0;
  logic [7:0]  a_m [R][KM];
  logic [7:0]  b_m [KM][C];
  logic [23:0] e24 [R][C];
  logic [15:0] e16 [R][C];

  sa_os_tile #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC_W(24), .KW(8)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy));

  sa_os_tile #(.ROWS(R), .COLS(C), .WIDTH(W), .ACC_W(16), .KW(8)) u_dut16 (
    .CLK(CLK), .RST(RST), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .in_valid(in_valid), .in_ready(in_ready16), .a_data(a_data), .b_data(b_data),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
    .out_row(out_row16), .out_last(out_last16), .busy(busy16));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: plain matrix product over the first kk steps, wrapped to 24 and 16 bits.
  task automatic model(input int kk, input bit sgn);
    longint s, av, bv;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        s = 0;
        for (int k = 0; k < kk; k++) begin
          av = longint'(a_m[r][k]);
          bv = longint'(b_m[k][c]);
          if (sgn && av > 127) av -= 256;
          if (sgn && bv > 127) bv -= 256;
          s += av * bv;
        end
        e24[r][c] = s[23:0];
        e16[r][c] = s[15:0];
      end
    end
  endtask

  task automatic fill_const(input int kk, input logic [7:0] av, input logic [7:0] bv);
    for (int k = 0; k < kk; k++) begin
      for (int r = 0; r < R; r++) a_m[r][k] = av;
      for (int c = 0; c < C; c++) b_m[k][c] = bv;
    end
  endtask

  task automatic fill_rand(input int kk);
    for (int k = 0; k < kk; k++) begin
      for (int r = 0; r < R; r++) a_m[r][k] = 8'($urandom);
      for (int c = 0; c < C; c++) b_m[k][c] = 8'($urandom);
    end
  endtask

  task automatic start_load(input int kk, input bit sgn, input bit gaps);
    int g;
    model(kk, sgn);
    start = 1'b1; k_len = 8'(kk); signed_mode = sgn;
    tick();
    start = 1'b0; signed_mode = ~sgn;
    chk("busy_load", busy, 1);
    for (int k = 0; k < kk; k++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        g = $urandom_range(1, 3);
        in_valid = 1'b0;
        repeat (g) begin
          a_data = R*W'($urandom); b_data = C*W'($urandom);
          chk("ready_in_gap", in_ready, 1);
          tick();
        end
      end
      in_valid = 1'b1;
      for (int r = 0; r < R; r++) a_data[r*W +: W] = a_m[r][k];
      for (int c = 0; c < C; c++) b_data[c*W +: W] = b_m[k][c];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Cycle t+1 after the last beat counts as 1; out_valid must rise at ROWS+COLS-1.
  task automatic wait_valid();
    int cyc;
    cyc = 1;
    in_valid = 1'b1;
    while (!out_valid && cyc < 64) begin
      a_data = R*W'($urandom); b_data = C*W'($urandom);
      chk("ready_flush", in_ready, 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("latency", cyc, R + C - 1);
  endtask

  task automatic drain(input int stall_row, input int stall_n);
    int hs, cyc, st;
    logic [C*24-1:0] held;
    logic [1:0] held_row;
    hs = 0; cyc = 0; st = 0; held = '0; held_row = '0;
    while (hs < R && cyc < 200) begin
      out_ready = !(out_valid && int'(out_row) == stall_row && st < stall_n);
      chk("valid_drain", out_valid, 1);
      chk("ready_drain", in_ready, 0);
      if (!out_ready) begin
        if (st > 0) begin
          chk("hold_data", out_data, held);
          chk("hold_row", out_row, held_row);
        end
        held = out_data; held_row = out_row; st++;
      end else begin
        chk("row_idx", out_row, hs);
        chk("row_last", out_last, (hs == R - 1) ? 1 : 0);
        chk("row16_valid", out_valid16, 1);
        for (int c = 0; c < C; c++) begin
          chk($sformatf("c24_r%0d_c%0d", hs, c), out_data[c*24 +: 24], e24[hs][c]);
          chk($sformatf("c16_r%0d_c%0d", hs, c), out_data16[c*16 +: 16], e16[hs][c]);
        end
        if (hs == R - 1) begin
          start = 1'b1; k_len = 8'd3;
        end
        hs++;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    chk("handshakes", hs, R);
    chk("stall_cycles", st, stall_n);
    chk("valid_after", out_valid, 0);
    chk("busy_after", busy, 0);
    chk("last_after", out_last, 0);
    tick();
    chk("busy_idle", busy, 0);
    chk("ready_idle", in_ready, 0);
  endtask

  task automatic run_job(input int kk, input bit sgn, input bit gaps, input int srow, input int sn);
    start_load(kk, sgn, gaps);
    wait_valid();
    drain(srow, sn);
  endtask

  initial begin
    int kk, cyc;
    RST = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; a_data = '0; b_data = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_row", out_row, 0);
    chk("rst_data", out_data, 0);

    // 1: K=1, a=[1,2,3,4], b=1 -> row r all r+1.
    fill_const(1, 8'd0, 8'd1);
    for (int r = 0; r < R; r++) a_m[r][0] = 8'(r + 1);
    run_job(1, 1'b0, 1'b0, -1, 0);
    chk("t1_c00", e24[0][0], 24'd1);
    chk("t1_c33", e24[3][3], 24'd4);

    // 2: 0xFF x 0x02 over K=2, signed then unsigned.
    fill_const(2, 8'hFF, 8'h02);
    run_job(2, 1'b1, 1'b0, -1, 0);
    chk("t2_signed", out_data[23:0], 24'hFFFFFC);
    run_job(2, 1'b0, 1'b0, -1, 0);
    chk("t2_unsigned", out_data[23:0], 24'h0003FC);

    // 3: K=4 random with gaps, then the same data without gaps.
    fill_rand(4);
    run_job(4, 1'b1, 1'b1, -1, 0);
    run_job(4, 1'b1, 1'b0, -1, 0);

    // 4: stall row 1 for 5 cycles.
    fill_rand(2);
    run_job(2, 1'b0, 1'b1, 1, 5);

    // 5: 16-bit accumulator wrap; the 16-bit instance is checked against 0xFC02.
    fill_const(2, 8'hFF, 8'hFF);
    run_job(2, 1'b0, 1'b0, -1, 0);
    chk("t5_wrap16", out_data16[15:0], 16'hFC02);

    // 6a: start with K=0 is ignored.
    start = 1'b1; k_len = 8'd0;
    tick();
    start = 1'b0;
    chk("k0_busy", busy, 0);
    chk("k0_ready", in_ready, 0);
    tick();
    chk("k0_busy2", busy, 0);

    // 6b: reset while row 2 is presented.
    fill_rand(3);
    start_load(3, 1'b0, 1'b0);
    wait_valid();
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && out_row == 2'd2) && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("reach_row2", out_row, 2);
    out_ready = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_row", out_row, 0);
    chk("mid_rst_data", out_data, 0);

    // 6c: fresh K=1 job shows no residue.
    fill_const(1, 8'd1, 8'd5);
    run_job(1, 1'b0, 1'b0, -1, 0);
    chk("fresh_c", out_data[23:0], 24'd5);

    // Extra randomized jobs.
    for (int j = 0; j < 3; j++) begin
      kk = $urandom_range(1, KM);
      fill_rand(kk);
      run_job(kk, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, R - 1), $urandom_range(0, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sa_os_tile.md
Name: sa_os_tile

Overview:
- Parametrised output-stationary systolic matrix-multiply tile computing C[ROWS][COLS] = A[ROWS][K] x B[K][COLS], with K selected per job at run time.
- Contains the input skew buffers, a control FSM, valid/ready streaming on input and output, a signed/unsigned mode, and a row-serial result drain.
- Sits between the operand feeders and the result writeback in the accelerator datapath.

Parameters:
ROWS, 4, PE rows (rows of A and C), >=1
COLS, 4, PE columns (columns of B and C), >=1
WIDTH, 8, operand width in bits
ACC_W, 24, accumulator and result width in bits, >= 2*WIDTH
KW, 8, width of k_len

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  reset, synchronous, active-high
start  in  1  job start pulse; honoured only in IDLE
k_len  in  KW  reduction length K, sampled with start
signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid & in_ready
a_data  in  ROWS*WIDTH  column k of A; row r at [r*WIDTH +: WIDTH]
b_data  in  COLS*WIDTH  row k of B; column c at [c*WIDTH +: WIDTH]
out_valid  out  1  result row valid
out_ready  in  1  result row consumed when out_valid & out_ready
out_data  out  COLS*ACC_W  C[out_row][c] at [c*ACC_W +: ACC_W]
out_row  out  clog2(ROWS) (min 1)  row index of out_data
out_last  out  1  high with out_valid on row ROWS-1
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: FSM goes to IDLE. in_ready, out_valid, out_last and busy are 0. out_row is 0. out_data, all accumulators and all skew/PE registers are 0. RST has priority over every other input in the same cycle, including mid-job.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE -> LOAD:
  - Taken when start=1 and k_len!=0.
  - k_len and signed_mode are latched.
  - All accumulators and skew/PE pipeline registers clear on the same edge.
  - start with k_len=0 is ignored; FSM stays in IDLE.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready=1.
  - Each accepted beat is one k step, k = 0..K-1.
  - The array advances only on accepted beats. A cycle with in_valid=0 freezes all skew, PE and accumulator registers, so gaps never change results.
  - After beat K-1 is accepted: go to FLUSH if ROWS+COLS-2 > 0, otherwise go to DRAIN.
- Skew and dataflow:
  - A row r is delayed r advances before PE(r,0). B column c is delayed c advances before PE(0,c).
  - A values move right and B values move down one PE per advance.
  - PE(r,c) accumulates a[r][k]*b[k][c] on advance edge k+r+c.
- FLUSH:
  - Runs exactly ROWS+COLS-2 cycles. Each cycle is an advance with zeros injected at the skew inputs.
  - in_ready=0.
  - Then go to DRAIN.
- Latency: if the last beat is accepted in cycle t, out_valid first rises in cycle t+ROWS+COLS-1 (t+7 for 4x4).
- Arithmetic:
  - Each product is full-width 2*WIDTH. It is sign-extended when signed_mode=1 and zero-extended when signed_mode=0, up to ACC_W.
  - Accumulation wraps modulo 2^ACC_W. There is no saturation.
- DRAIN:
  - Rows are presented in order 0..ROWS-1, one row per handshake.
  - out_data and out_row are held stable while out_valid=1 and out_ready=0.
  - The next row is presented in the cycle after a handshake, so the rate is one row per cycle under continuous out_ready.
  - out_last=1 only on row ROWS-1.
  - The handshake on the last row returns the FSM to IDLE. busy and out_valid drop in the following cycle, and a new start is accepted from that cycle.
- Simultaneous events: in_valid in IDLE, FLUSH or DRAIN is ignored. start asserted together with the final drain handshake is ignored.
- Accumulators are not cleared by drain, only by start or RST.

Test Plan:
1. Defaults. start with K=1, unsigned, a=[1,2,3,4], b=[1,1,1,1], beat accepted in cycle t -> out_valid rises at t+7. Rows 0..3 have every column = 1,2,3,4. out_last on row 3 only; busy=0 after.
2. K=2, a all 0xFF, b all 0x02. signed_mode=1 -> every C = 0xFFFFFC (-4). Repeat with signed_mode=0 -> every C = 0x0003FC (1020).
3. K=4, random A/B with in_valid deasserted randomly (1-3 cycle gaps) -> results match the reference matmul and a gap-free run. in_ready=0 outside LOAD.
4. out_ready held low 5 cycles while row 1 is presented -> out_data and out_row=1 stable throughout, no row lost or duplicated, exactly 4 handshakes.
5. ACC_W=16, K=2, unsigned, all operands 0xFF -> every C = 0xFC02 (130050 mod 65536).
6. Robustness:
   - start with k_len=0 -> stays IDLE, busy=0.
   - RST asserted during DRAIN row 2 -> next cycle out_valid=0 and busy=0.
   - A new K=1 job with a=[1,1,1,1], b=[5,5,5,5] -> all C = 5, with no residue from the old job.
